// File: rtl/ysyx_25020047_idu_stage.sv
// Decode stage: decodes one instruction per cycle, reads the register file,
// tracks pending writes in a busy scoreboard and stalls on RAW/WAW hazards.
module ysyx_25020047_idu_stage #(
    parameter int NR_REG = 32,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_inst,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst_type,
    output logic [31:0] out_imm,
    output logic [31:0] out_rs1_data,
    output logic [31:0] out_rs2_data,
    output logic [4:0]  out_rd,
    output logic        out_rd_wen,
    output logic        out_illegal,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        flush
);

    localparam int         IW       = $clog2(NR_REG);
    localparam logic [5:0] NR_LIMIT = 6'(NR_REG);

    localparam logic [2:0] FMT_BAD = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_U   = 3'd2;
    localparam logic [2:0] FMT_S   = 3'd3;
    localparam logic [2:0] FMT_B   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_R   = 3'd6;
    localparam logic [2:0] FMT_SYS = 3'd7;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  rd_idx;

    assign opcode  = in_inst[6:0];
    assign funct3  = in_inst[14:12];
    assign funct7  = in_inst[31:25];
    assign rs1_idx = in_inst[19:15];
    assign rs2_idx = in_inst[24:20];
    assign rd_idx  = in_inst[11:7];

    logic [31:0] dec_type;
    logic [2:0]  dec_fmt;

    always_comb begin
        dec_type = 32'hFFFF_FFFF;
        dec_fmt  = FMT_BAD;
        case (opcode)
            7'b0010011: begin
                dec_fmt = FMT_I;
                case (funct3)
                    3'b000:  dec_type = 32'h0000_0001;
                    3'b010:  dec_type = 32'h0000_1000;
                    3'b011:  dec_type = 32'h0000_2000;
                    default: dec_fmt  = FMT_BAD;
                endcase
            end
            7'b1100111: begin
                if (funct3 == 3'b000) begin
                    dec_fmt  = FMT_I;
                    dec_type = 32'h0000_0002;
                end
            end
            7'b0000011: begin
                dec_fmt = FMT_I;
                case (funct3)
                    3'b010:  dec_type = 32'h0000_0020;
                    3'b100:  dec_type = 32'h0000_0040;
                    default: dec_fmt  = FMT_BAD;
                endcase
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                case (funct3)
                    3'b000:  dec_type = 32'h0000_0100;
                    3'b001:  dec_type = 32'h0020_0000;
                    3'b010:  dec_type = 32'h0000_0080;
                    default: dec_fmt  = FMT_BAD;
                endcase
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                case (funct3)
                    3'b000:  dec_type = 32'h0000_4000;
                    3'b001:  dec_type = 32'h0000_8000;
                    default: dec_fmt  = FMT_BAD;
                endcase
            end
            7'b0110111: begin
                dec_fmt  = FMT_U;
                dec_type = 32'h0000_0010;
            end
            7'b0010111: begin
                dec_fmt  = FMT_U;
                dec_type = 32'h0000_0200;
            end
            7'b1101111: begin
                dec_fmt  = FMT_J;
                dec_type = 32'h0000_0400;
            end
            7'b0110011: begin
                dec_fmt = FMT_R;
                case ({funct7, funct3})
                    10'b0000000_000: dec_type = 32'h0000_0008;
                    10'b0100000_000: dec_type = 32'h0000_0800;
                    10'b0000000_010: dec_type = 32'h0001_0000;
                    10'b0000000_011: dec_type = 32'h0002_0000;
                    10'b0000000_100: dec_type = 32'h0004_0000;
                    10'b0000000_110: dec_type = 32'h0008_0000;
                    10'b0000000_111: dec_type = 32'h0010_0000;
                    default:         dec_fmt  = FMT_BAD;
                endcase
            end
            7'b1110011: begin
                if (in_inst == 32'h0010_0073) begin
                    dec_fmt  = FMT_SYS;
                    dec_type = 32'h0000_0004;
                end
            end
            default: ;
        endcase
    end

    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic [31:0] dec_imm;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        dec_imm = 32'h0;
        case (dec_fmt)
            FMT_I: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                dec_imm = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            FMT_U: begin
                use_rd  = 1'b1;
                dec_imm = {in_inst[31:12], 12'b0};
            end
            FMT_S: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            FMT_B: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                dec_imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
            end
            FMT_J: begin
                use_rd  = 1'b1;
                dec_imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                           in_inst[20], in_inst[30:21], 1'b0};
            end
            FMT_R: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            default: ;
        endcase
    end

    logic        range_bad;
    logic        illegal;
    logic        rd_wen;

    assign range_bad = (use_rs1 && ({1'b0, rs1_idx} >= NR_LIMIT)) ||
                       (use_rs2 && ({1'b0, rs2_idx} >= NR_LIMIT)) ||
                       (use_rd  && ({1'b0, rd_idx}  >= NR_LIMIT));
    assign illegal   = (dec_fmt == FMT_BAD) || range_bad;
    // An illegal instruction never writes back, so it must not claim rd.
    assign rd_wen    = use_rd && (rd_idx != 5'd0) && !illegal;

    logic [31:0]       rf [NR_REG];
    logic [NR_REG-1:0] busy_reg;

    logic fwd_rs1;
    logic fwd_rs2;
    logic haz_rs1;
    logic haz_rs2;
    logic haz_waw;
    logic hazard;

    assign fwd_rs1 = (BYPASS != 0) && wb_valid && (wb_rd == rs1_idx);
    assign fwd_rs2 = (BYPASS != 0) && wb_valid && (wb_rd == rs2_idx);
    assign haz_rs1 = use_rs1 && (rs1_idx != 5'd0) && busy_reg[rs1_idx[IW-1:0]] && !fwd_rs1;
    assign haz_rs2 = use_rs2 && (rs2_idx != 5'd0) && busy_reg[rs2_idx[IW-1:0]] && !fwd_rs2;
    assign haz_waw = rd_wen && busy_reg[rd_idx[IW-1:0]];
    assign hazard  = !illegal && (haz_rs1 || haz_rs2 || haz_waw);

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;

    always_comb begin
        rs1_val = 32'h0;
        rs2_val = 32'h0;
        if (use_rs1 && rs1_idx != 5'd0) begin
            rs1_val = fwd_rs1 ? wb_data : rf[rs1_idx[IW-1:0]];
        end
        if (use_rs2 && rs2_idx != 5'd0) begin
            rs2_val = fwd_rs2 ? wb_data : rf[rs2_idx[IW-1:0]];
        end
    end

    logic out_valid_reg;
    logic fire;
    logic accept_wr;

    assign in_ready  = (!out_valid_reg || out_ready) && !hazard && !flush;
    assign fire      = in_valid && in_ready;
    assign accept_wr = fire && rd_wen;

    logic [NR_REG-1:0] wb_hit;
    logic [NR_REG-1:0] set_hit;

    for (genvar gi = 0; gi < NR_REG; gi++) begin : g_reg_ctl
        assign wb_hit[gi]  = (gi != 0) && wb_valid  && (wb_rd  == 5'(gi));
        assign set_hit[gi] = (gi != 0) && accept_wr && (rd_idx == 5'(gi));
    end

    // Flops rather than RAM: cleared on reset and read combinationally with bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
            for (int i = 0; i < NR_REG; i++) begin
                rf[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < NR_REG; i++) begin
                if (wb_hit[i]) begin
                    rf[i] <= wb_data;
                end
                if (set_hit[i]) begin
                    busy_reg[i] <= 1'b1;
                end else if (wb_hit[i]) begin
                    busy_reg[i] <= 1'b0;
                end
            end
        end
    end

    logic [31:0] pc_reg;
    logic [31:0] type_reg;
    logic [31:0] imm_reg;
    logic [31:0] rs1_data_reg;
    logic [31:0] rs2_data_reg;
    logic [4:0]  rd_reg;
    logic        rd_wen_reg;
    logic        illegal_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            pc_reg        <= 32'h0;
            type_reg      <= 32'h0;
            imm_reg       <= 32'h0;
            rs1_data_reg  <= 32'h0;
            rs2_data_reg  <= 32'h0;
            rd_reg        <= 5'd0;
            rd_wen_reg    <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (flush) begin
            out_valid_reg <= 1'b0;
        end else if (fire) begin
            out_valid_reg <= 1'b1;
            pc_reg        <= in_pc;
            type_reg      <= dec_type;
            imm_reg       <= dec_imm;
            rs1_data_reg  <= rs1_val;
            rs2_data_reg  <= rs2_val;
            rd_reg        <= use_rd ? rd_idx : 5'd0;
            rd_wen_reg    <= rd_wen;
            illegal_reg   <= illegal;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid     = out_valid_reg;
    assign out_pc        = pc_reg;
    assign out_inst_type = type_reg;
    assign out_imm       = imm_reg;
    assign out_rs1_data  = rs1_data_reg;
    assign out_rs2_data  = rs2_data_reg;
    assign out_rd        = rd_reg;
    assign out_rd_wen    = rd_wen_reg;
    assign out_illegal   = illegal_reg;

endmodule

// File: tb/tb_ysyx_25020047_idu_stage.sv
// Directed bench for the decode stage: RV32I with bypass (a_*) and
// RV32E without bypass (b_*), checked against hand-computed values.
module tb_ysyx_25020047_idu_stage;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_rd_wen, a_out_illegal;
    logic        a_wb_valid, a_flush;
    logic [31:0] a_in_inst, a_in_pc, a_out_pc, a_out_type, a_out_imm, a_out_rs1, a_out_rs2, a_wb_data;
    logic [4:0]  a_out_rd, a_wb_rd;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_rd_wen, b_out_illegal;
    logic        b_wb_valid, b_flush;
    logic [31:0] b_in_inst, b_in_pc, b_out_pc, b_out_type, b_out_imm, b_out_rs1, b_out_rs2, b_wb_data;
    logic [4:0]  b_out_rd, b_wb_rd;

    ysyx_25020047_idu_stage #(.NR_REG(32), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inst(a_in_inst), .in_pc(a_in_pc),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_pc(a_out_pc),
        .out_inst_type(a_out_type), .out_imm(a_out_imm),
        .out_rs1_data(a_out_rs1), .out_rs2_data(a_out_rs2),
        .out_rd(a_out_rd), .out_rd_wen(a_out_rd_wen), .out_illegal(a_out_illegal),
        .wb_valid(a_wb_valid), .wb_rd(a_wb_rd), .wb_data(a_wb_data), .flush(a_flush)
    );

    ysyx_25020047_idu_stage #(.NR_REG(16), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inst(b_in_inst), .in_pc(b_in_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_pc(b_out_pc),
        .out_inst_type(b_out_type), .out_imm(b_out_imm),
        .out_rs1_data(b_out_rs1), .out_rs2_data(b_out_rs2),
        .out_rd(b_out_rd), .out_rd_wen(b_out_rd_wen), .out_illegal(b_out_illegal),
        .wb_valid(b_wb_valid), .wb_rd(b_wb_rd), .wb_data(b_wb_data), .flush(b_flush)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One line per decoded transaction, then field-by-field comparison.
    task automatic chk_out(input string tag, input logic vld, input logic [31:0] pc,
                           input logic [31:0] typ, input logic [31:0] imm,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [4:0] rd, input logic wen, input logic ill,
                           input logic [31:0] e_pc, input logic [31:0] e_typ,
                           input logic [31:0] e_imm, input logic [31:0] e_r1,
                           input logic [31:0] e_r2, input logic [4:0] e_rd,
                           input logic e_wen, input logic e_ill);
        $display("txn %s pc=%08h type=%08h imm=%08h rs1=%08h rs2=%08h rd=%0d wen=%0d ill=%0d",
                 tag, pc, typ, imm, r1, r2, rd, wen, ill);
        check({tag, "_valid"}, {31'b0, vld}, 32'd1);
        check({tag, "_pc"},    pc,  e_pc);
        check({tag, "_type"},  typ, e_typ);
        check({tag, "_imm"},   imm, e_imm);
        check({tag, "_rs1"},   r1,  e_r1);
        check({tag, "_rs2"},   r2,  e_r2);
        check({tag, "_rd"},    {27'b0, rd}, {27'b0, e_rd});
        check({tag, "_wen"},   {31'b0, wen}, {31'b0, e_wen});
        check({tag, "_ill"},   {31'b0, ill}, {31'b0, e_ill});
    endtask

    task automatic a_chk(input string tag, input logic [31:0] e_pc, input logic [31:0] e_typ,
                         input logic [31:0] e_imm, input logic [31:0] e_r1, input logic [31:0] e_r2,
                         input logic [4:0] e_rd, input logic e_wen, input logic e_ill);
        chk_out(tag, a_out_valid, a_out_pc, a_out_type, a_out_imm, a_out_rs1, a_out_rs2,
                a_out_rd, a_out_rd_wen, a_out_illegal,
                e_pc, e_typ, e_imm, e_r1, e_r2, e_rd, e_wen, e_ill);
    endtask

    task automatic b_chk(input string tag, input logic [31:0] e_pc, input logic [31:0] e_typ,
                         input logic [31:0] e_imm, input logic [31:0] e_r1, input logic [31:0] e_r2,
                         input logic [4:0] e_rd, input logic e_wen, input logic e_ill);
        chk_out(tag, b_out_valid, b_out_pc, b_out_type, b_out_imm, b_out_rs1, b_out_rs2,
                b_out_rd, b_out_rd_wen, b_out_illegal,
                e_pc, e_typ, e_imm, e_r1, e_r2, e_rd, e_wen, e_ill);
    endtask

    initial begin
        a_in_valid = 0; a_in_inst = 0; a_in_pc = 0; a_out_ready = 0;
        a_wb_valid = 0; a_wb_rd = 0; a_wb_data = 0; a_flush = 0;
        b_in_valid = 0; b_in_inst = 0; b_in_pc = 0; b_out_ready = 0;
        b_wb_valid = 0; b_wb_rd = 0; b_wb_data = 0; b_flush = 0;

        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_a_valid", {31'b0, a_out_valid}, 32'd0);
        check("rst_a_type",  a_out_type, 32'h0);
        check("rst_a_imm",   a_out_imm,  32'h0);
        check("rst_a_rs1",   a_out_rs1,  32'h0);
        check("rst_a_ready", {31'b0, a_in_ready}, 32'd1);
        check("rst_b_valid", {31'b0, b_out_valid}, 32'd0);
        check("rst_b_ready", {31'b0, b_in_ready}, 32'd1);

        // addi x1,x0,5
        a_in_valid = 1; a_in_inst = 32'h0050_0093; a_in_pc = 32'h8000_0000;
        #1 check("a_addi_rdy", {31'b0, a_in_ready}, 32'd1);
        step();
        a_chk("a_addi", 32'h8000_0000, 32'h1, 32'h5, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);

        // add x2,x1,x1: RAW on x1 until writeback, bypassed the same cycle
        a_in_inst = 32'h0010_8133; a_in_pc = 32'h8000_0004; a_out_ready = 1;
        #1 check("a_raw_stall", {31'b0, a_in_ready}, 32'd0);
        step();
        check("a_drain", {31'b0, a_out_valid}, 32'd0);
        check("a_raw_stall2", {31'b0, a_in_ready}, 32'd0);
        a_wb_valid = 1; a_wb_rd = 5'd1; a_wb_data = 32'd5;
        #1 check("a_bypass_rel", {31'b0, a_in_ready}, 32'd1);
        step();
        a_wb_valid = 0;
        a_chk("a_add", 32'h8000_0004, 32'h8, 32'h0, 32'd5, 32'd5, 5'd2, 1'b1, 1'b0);

        // back-pressure for 3 cycles, then three independent addis
        a_out_ready = 0; a_in_inst = 32'h0070_0193; a_in_pc = 32'h8000_0008;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("a_hold_rdy",  {31'b0, a_in_ready}, 32'd0);
            check("a_hold_type", a_out_type, 32'h8);
            check("a_hold_pc",   a_out_pc, 32'h8000_0004);
            step();
        end
        a_out_ready = 1;
        #1 check("a_hold_rel", {31'b0, a_in_ready}, 32'd1);
        step();
        a_chk("a_addi3", 32'h8000_0008, 32'h1, 32'd7, 32'h0, 32'h0, 5'd3, 1'b1, 1'b0);
        a_in_inst = 32'h0080_0213; a_in_pc = 32'h8000_000C;
        step();
        a_chk("a_addi4", 32'h8000_000C, 32'h1, 32'd8, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0);
        a_in_inst = 32'h0090_0293; a_in_pc = 32'h8000_0010;
        step();
        a_chk("a_addi5", 32'h8000_0010, 32'h1, 32'd9, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0);

        // beq x0,x0,-4
        a_in_inst = 32'hFE00_0EE3; a_in_pc = 32'h8000_0014;
        step();
        a_chk("a_beq", 32'h8000_0014, 32'h4000, 32'hFFFF_FFFC, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

        // sh x2,-2(x1): x2 busy until its writeback is bypassed
        a_in_inst = 32'hFE20_9F23; a_in_pc = 32'h8000_0018;
        #1 check("a_sh_stall", {31'b0, a_in_ready}, 32'd0);
        a_wb_valid = 1; a_wb_rd = 5'd2; a_wb_data = 32'h0000_000A;
        #1 check("a_sh_rel", {31'b0, a_in_ready}, 32'd1);
        step();
        a_wb_valid = 0;
        a_chk("a_sh", 32'h8000_0018, 32'h0020_0000, 32'hFFFF_FFFE, 32'd5, 32'h0000_000A, 5'd0, 1'b0, 1'b0);

        // addi x3,x0,1 while x3 pending: WAW stall
        a_in_inst = 32'h0010_0193; a_in_pc = 32'h8000_001C;
        #1 check("a_waw_stall", {31'b0, a_in_ready}, 32'd0);
        a_in_valid = 0;
        step();

        a_in_valid = 1; a_in_inst = 32'hFFFF_FFFF; a_in_pc = 32'h8000_0020;
        #1 check("a_ill_rdy", {31'b0, a_in_ready}, 32'd1);
        step();
        a_chk("a_ill", 32'h8000_0020, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        a_in_inst = 32'h0010_0073; a_in_pc = 32'h8000_0024;
        step();
        a_chk("a_ebreak", 32'h8000_0024, 32'h4, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
        a_in_inst = 32'h1234_5337; a_in_pc = 32'h8000_0028;
        step();
        a_chk("a_lui", 32'h8000_0028, 32'h10, 32'h1234_5000, 32'h0, 32'h0, 5'd6, 1'b1, 1'b0);

        // flush with a held output and an offered input
        a_flush = 1; a_in_inst = 32'h0030_0393; a_in_pc = 32'h8000_002C;
        #1 check("a_flush_rdy", {31'b0, a_in_ready}, 32'd0);
        step();
        a_flush = 0;
        check("a_flush_drop", {31'b0, a_out_valid}, 32'd0);
        a_in_inst = 32'h0003_0413;
        #1 check("a_busy_kept", {31'b0, a_in_ready}, 32'd0);
        a_in_inst = 32'h0003_8493; a_in_pc = 32'h8000_0030;
        #1 check("a_flush_noacc", {31'b0, a_in_ready}, 32'd1);
        step();
        a_chk("a_addi9", 32'h8000_0030, 32'h1, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1, 1'b0);

        // writeback to x0 is ignored, both bypassed and stored
        a_wb_valid = 1; a_wb_rd = 5'd0; a_wb_data = 32'h0000_DEAD;
        a_in_inst = 32'h0000_0533; a_in_pc = 32'h8000_0034;
        step();
        a_wb_valid = 0;
        a_chk("a_x0_byp", 32'h8000_0034, 32'h8, 32'h0, 32'h0, 32'h0, 5'd10, 1'b1, 1'b0);
        a_in_inst = 32'h0000_05B3; a_in_pc = 32'h8000_0038;
        step();
        a_chk("a_x0_rf", 32'h8000_0038, 32'h8, 32'h0, 32'h0, 32'h0, 5'd11, 1'b1, 1'b0);
        a_in_valid = 0;
        step();

        // RV32E instance without bypass
        b_out_ready = 1; b_in_valid = 1; b_in_inst = 32'h0050_0093; b_in_pc = 32'h0000_0100;
        step();
        b_chk("b_addi", 32'h0000_0100, 32'h1, 32'd5, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
        b_in_inst = 32'h0010_8133; b_in_pc = 32'h0000_0104;
        #1 check("b_raw_stall", {31'b0, b_in_ready}, 32'd0);
        b_wb_valid = 1; b_wb_rd = 5'd1; b_wb_data = 32'd5;
        #1 check("b_nobyp_stall", {31'b0, b_in_ready}, 32'd0);
        step();
        b_wb_valid = 0;
        #1 check("b_nobyp_rel", {31'b0, b_in_ready}, 32'd1);
        step();
        b_chk("b_add", 32'h0000_0104, 32'h8, 32'h0, 32'd5, 32'd5, 5'd2, 1'b1, 1'b0);

        // addi x17,x0,1: out of range on RV32E
        b_in_inst = 32'h0010_0893; b_in_pc = 32'h0000_0108;
        #1 check("b_x17_rdy", {31'b0, b_in_ready}, 32'd1);
        step();
        $display("txn b_x17 pc=%08h ill=%0d wen=%0d", b_out_pc, b_out_illegal, b_out_rd_wen);
        check("b_x17_ill", {31'b0, b_out_illegal}, 32'd1);
        check("b_x17_wen", {31'b0, b_out_rd_wen}, 32'd0);
        check("b_x17_pc",  b_out_pc, 32'h0000_0108);
        // add x3,x1,x0 must not stall: the illegal x17 left busy alone
        b_in_inst = 32'h0000_81B3; b_in_pc = 32'h0000_010C;
        #1 check("b_busy_same", {31'b0, b_in_ready}, 32'd1);
        step();
        b_chk("b_add3", 32'h0000_010C, 32'h8, 32'h0, 32'd5, 32'h0, 5'd3, 1'b1, 1'b0);
        b_in_inst = 32'hFFFF_FFFF; b_in_pc = 32'h0000_0110;
        step();
        b_chk("b_ill", 32'h0000_0110, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1);
        b_in_valid = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_idu_stage.md
# ysyx_25020047_idu_stage

Pipelined decode stage for the NPC core: accepts one fetched instruction per cycle from the IFU over a valid/ready handshake and decodes it into one-hot type, immediate and register operands. It holds the integer register file and a per-register busy scoreboard, and stalls on RAW/WAW hazards. Results go to the EXU through a registered valid/ready output. Register count (RV32I/RV32E) and writeback-to-decode bypass are parameters.

## Interface
- NR_REG, 32, number of architectural registers; 32 (RV32I) or 16 (RV32E)
- BYPASS, 1, 1 = writeback data forwarded to same-cycle operand read; 0 = no forwarding
- clk  input  1  clock; one clock domain
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  IFU offers in_inst/in_pc
- in_ready  output  1  stage accepts this cycle
- in_inst  input  32  instruction word
- in_pc  input  32  instruction address
- out_valid  output  1  decoded instruction held for EXU
- out_ready  input  1  EXU consumes this cycle
- out_pc  output  32  pc of held instruction
- out_inst_type  output  32  one-hot type code (table below)
- out_imm  output  32  extended immediate
- out_rs1_data, out_rs2_data  output  32 each  operand values
- out_rd  output  5  destination index
- out_rd_wen  output  1  instruction writes rd (rd != 0)
- out_illegal  output  1  undecodable or register index >= NR_REG
- wb_valid  input  1  writeback strobe
- wb_rd  input  5  writeback index
- wb_data  input  32  writeback value
- flush  input  1  redirect: drop held output, refuse input this cycle

## Operation
- Type codes: addi 0x1, jalr 0x2, ebreak 0x4, add 0x8, lui 0x10, lw 0x20, lbu 0x40, sw 0x80, sb 0x100, auipc 0x200, jal 0x400, sub 0x800, slti 0x1000, sltiu 0x2000, beq 0x4000, bne 0x8000, slt 0x10000, sltu 0x20000, xor 0x40000, or 0x80000, and 0x100000, sh 0x200000; anything else 0xFFFFFFFF with out_illegal=1.
- Immediates: I-type sign-extended inst[31:20]; U-type {inst[31:12],12'b0}; S-type (sw/sb/sh) sign-extended {inst[31:25],inst[11:7]}; B-type sign-extended {inst[31],inst[7],inst[30:25],inst[11:8],0}; J-type sign-extended {inst[31],inst[19:12],inst[20],inst[30:21],0}; R-type and ebreak 0.
- Field use: rs1 used by all except lui/auipc/jal/ebreak; rs2 used by R, S, B; rd written by U, J, I (incl. loads/jalr), R. Unused field index forced to 0 on outputs; unused operand data is 0.
- Register file: NR_REG x 32; x0 reads 0; writes to x0 or to wb_rd >= NR_REG ignored. NR_REG=16: any used field index >= 16 sets out_illegal.
- Scoreboard busy[NR_REG]: set busy[rd] on accept of a non-illegal instruction with rd_wen; clear busy[wb_rd] on wb_valid. Same-cycle set and clear on same index: set wins.
- Hazard (combinational on in_inst): used rs1/rs2 busy, or rd_wen and busy[rd] (WAW). With BYPASS=1 a busy source whose index equals wb_rd while wb_valid is not a hazard; operand takes wb_data. Index 0 never hazards.
- in_ready = (~out_valid | out_ready) & ~hazard & ~flush. Illegal instructions never hazard and never touch busy.
- flush: out_valid cleared next edge; busy bits untouched (in-flight instructions still write back).

## Timing
- Reset: out_valid 0, all busy 0, all registers 0, all out_* data 0, in_ready follows its equation (1 after reset with in_valid).
- Accept at edge N -> out_valid=1 after edge N; latency 1 cycle, throughput 1/cycle with no hazards.
- Output registers stable while out_valid & ~out_ready.
- Register write and busy clear take effect at the edge; BYPASS=0 releases a stall one cycle after wb_valid, BYPASS=1 the same cycle.
- flush and accept same cycle: flush wins, nothing accepted. rst mid-operation overrides everything.

## Test plan
- Reset then addi x1,x0,5 (0x00500093) -> one cycle later out_inst_type=0x1, out_imm=5, out_rd=1, out_rd_wen=1, busy[1]=1.
- add x2,x1,x1 after it, no wb -> in_ready=0; wb_valid rd=1 data=5 -> BYPASS=1 accepted that cycle with both operands 5; BYPASS=0 one cycle later.
- out_ready=0 for 3 cycles with back-to-back independent inputs -> outputs held, in_ready=0, no input lost or duplicated.
- NR_REG=16, addi x17,x0,1 -> out_illegal=1, busy unchanged; 0xFFFFFFFF word -> type 0xFFFFFFFF.
- beq imm -4 (0xFE000EE3) -> out_imm=0xFFFFFFFC; sh x2,-2(x1) -> type 0x200000, imm 0xFFFFFFFE.
- flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not accepted, busy bits retained; wb_rd=0 data 0xDEAD -> x0 still reads 0.
